// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame serializer with a programmable 1..8 bit pattern matcher.
// Each accepted byte is shifted out MSB first over exactly 8 cycles. Every
// shifted bit enters a history register that is compared against the
// configured pattern. Matches may overlap and may span byte boundaries.
module seq_scan_ctrl (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       cfg_we,
    input  logic [7:0] cfg_pat,
    input  logic [2:0] cfg_len,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] din,
    input  logic       din_last,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic       bit_o,
    output logic       shift_en,
    output logic       hit,
    output logic [7:0] match_cnt,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pat_q, pat_d;
    logic [2:0] len_q, len_d;
    logic [7:0] sr_q, sr_d;          // captured byte, MSB is the bit on the wire
    logic       last_q, last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] hist_q, hist_d;      // bit 0 = most recent serial bit
    logic [3:0] seen_q, seen_d;      // bits seen in this frame, saturates at 8
    logic       hit_q, hit_d;
    logic [7:0] cnt_q, cnt_d;

    logic [7:0] next_hist;
    logic [7:0] len_mask;
    logic [3:0] seen_inc;
    logic [3:0] len_bits;
    logic       match;

    // Next-state, datapath and match evaluation for the scan FSM
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        sr_d      = sr_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;
        hist_d    = hist_q;
        seen_d    = seen_q;
        hit_d     = 1'b0;
        cnt_d     = cnt_q;

        // Compare the history as it will look once the current bit is in,
        // so the match is known in the same cycle the bit is on the wire.
        next_hist = {hist_q[6:0], sr_q[7]};
        len_mask  = 8'hFF >> (3'd7 - len_q);
        seen_inc  = seen_q + 4'd1;
        len_bits  = {1'b0, len_q} + 4'd1;
        match     = (((next_hist ^ pat_q) & len_mask) == 8'h00) && (seen_inc >= len_bits);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = 8'd0;
                    hist_d  = 8'd0;
                    seen_d  = 4'd0;
                end else if (cfg_we) begin
                    pat_d = cfg_pat;
                    len_d = cfg_len;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (din_vld) begin
                    sr_d      = din;
                    last_d    = din_last;
                    bit_cnt_d = 3'd0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    hist_d    = next_hist;
                    seen_d    = (seen_q >= 4'd8) ? 4'd8 : seen_inc;
                    sr_d      = sr_q << 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (match) begin
                        hit_d = 1'b1;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    if (bit_cnt_q == 3'd7) begin
                        state_d = last_q ? S_DONE : S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset restores the default 5-bit pattern 10110
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            pat_q     <= 8'h16;
            len_q     <= 3'd4;
            sr_q      <= 8'd0;
            last_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
            hist_q    <= 8'd0;
            seen_q    <= 4'd0;
            hit_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            sr_q      <= sr_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            hist_q    <= hist_d;
            seen_q    <= seen_d;
            hit_q     <= hit_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs decode straight from registered state; only din_rdy also sees abort
    always_comb begin
        busy      = (state_q != S_IDLE);
        din_rdy   = (state_q == S_LOAD) && !abort;
        shift_en  = (state_q == S_SHIFT);
        bit_o     = (state_q == S_SHIFT) && sr_q[7];
        done      = (state_q == S_DONE);
        hit       = hit_q;
        match_cnt = cnt_q;
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       cfg_we;
    logic [7:0] cfg_pat;
    logic [2:0] cfg_len;
    logic       start;
    logic       abort;
    logic [7:0] din;
    logic       din_last;
    logic       din_vld;
    logic       din_rdy;
    logic       bit_o;
    logic       shift_en;
    logic       hit;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .start     (start),
        .abort     (abort),
        .din       (din),
        .din_last  (din_last),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .bit_o     (bit_o),
        .shift_en  (shift_en),
        .hit       (hit),
        .match_cnt (match_cnt),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a frame from IDLE: LOAD is reached one edge later
    task automatic begin_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Send one byte from LOAD; hmask[k] = hit observed after shift cycle k
    task automatic send_byte(input logic [7:0] b, input logic last, output logic [7:0] hmask);
        check_val("rdy_in_load", din_rdy, 1);
        din      = b;
        din_last = last;
        din_vld  = 1'b1;
        step();
        din_vld  = 1'b0;
        hmask    = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check_val("shift_en", shift_en, 1);
            check_val("bit_o", bit_o, b[7-k]);
            step();
            hmask[k] = hit;
        end
        if (last) begin
            check_val("done_after_last", done, 1);
        end else begin
            check_val("back_to_load", din_rdy, 1);
            check_val("no_shift_in_load", shift_en, 0);
        end
        $display("byte %02h last=%0d hits=%02h match_cnt=%0d", b, last, hmask, match_cnt);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_din_rdy"}, din_rdy, 0);
        check_val({tag, "_shift_en"}, shift_en, 0);
        check_val({tag, "_bit_o"}, bit_o, 0);
        check_val({tag, "_hit"}, hit, 0);
        check_val({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [7:0] hm;

        rst_b    = 1'b0;
        cfg_we   = 1'b0;
        cfg_pat  = 8'h00;
        cfg_len  = 3'd0;
        start    = 1'b0;
        abort    = 1'b0;
        din      = 8'h00;
        din_last = 1'b0;
        din_vld  = 1'b0;

        // Reset state
        step();
        step();
        check_idle_outputs("reset");
        check_val("reset_cnt", match_cnt, 0);
        #2 rst_b = 1'b1;
        step();

        // Default pattern 10110 on byte 0xB6: matches on bits 5 and 8
        begin_frame();
        check_val("busy_load", busy, 1);
        send_byte(8'hB6, 1'b1, hm);
        check_val("b6_hits", hm, 8'h90);
        check_val("b6_cnt_done", match_cnt, 2);
        check_val("b6_busy_done", busy, 1);
        check_val("b6_hit_in_done", hit, 1);
        step();
        check_val("b6_done_pulse", done, 0);
        check_val("b6_idle", busy, 0);
        check_val("b6_hit_clear", hit, 0);
        step();
        step();
        check_val("cnt_hold_idle", match_cnt, 2);

        // Cross-byte match: 0x01 then 0x60, single hit at byte 2 shift 4
        begin_frame();
        check_val("cnt_cleared_at_start", match_cnt, 0);
        send_byte(8'h01, 1'b0, hm);
        check_val("xb_hits1", hm, 8'h00);
        send_byte(8'h60, 1'b1, hm);
        check_val("xb_hits2", hm, 8'h08);
        check_val("xb_cnt", match_cnt, 1);
        step();

        // cfg_we alongside start is ignored; LOAD waits for din_vld
        cfg_we  = 1'b1;
        cfg_pat = 8'h01;
        cfg_len = 3'd0;
        begin_frame();
        cfg_we  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("hs_rdy", din_rdy, 1);
            check_val("hs_no_shift", shift_en, 0);
            check_val("hs_busy", busy, 1);
            step();
        end
        start = 1'b1;
        send_byte(8'hB6, 1'b1, hm);
        start = 1'b0;
        check_val("hs_hits", hm, 8'h90);
        check_val("hs_cnt", match_cnt, 2);
        step();
        check_val("hs_idle", busy, 0);

        // Abort in the third shift cycle with a 1-bit pattern "1"
        cfg_we  = 1'b1;
        cfg_pat = 8'h01;
        cfg_len = 3'd0;
        step();
        cfg_we  = 1'b0;
        begin_frame();
        din      = 8'hC0;
        din_last = 1'b1;
        din_vld  = 1'b1;
        step();
        din_vld  = 1'b0;
        step();
        step();
        check_val("ab_cnt_before", match_cnt, 2);
        abort = 1'b1;
        check_val("ab_busy_before", busy, 1);
        step();
        abort = 1'b0;
        check_val("ab_idle", busy, 0);
        check_val("ab_shift_off", shift_en, 0);
        check_val("ab_cnt_held", match_cnt, 2);
        for (int i = 0; i < 10; i++) begin
            check_val("ab_no_done", done, 0);
            step();
        end
        $display("abort in shift: match_cnt=%0d busy=%0d", match_cnt, busy);

        // Abort in IDLE ignored; abort in LOAD refuses the offered byte
        abort = 1'b1;
        begin_frame();
        check_val("ab_idle_ignored", busy, 1);
        din     = 8'hFF;
        din_vld = 1'b1;
        check_val("ab_load_rdy", din_rdy, 0);
        step();
        abort   = 1'b0;
        din_vld = 1'b0;
        check_val("ab_load_idle", busy, 0);
        check_val("ab_load_noshift", shift_en, 0);

        // Configuration accepted after abort: default pattern again
        cfg_we  = 1'b1;
        cfg_pat = 8'h16;
        cfg_len = 3'd4;
        step();
        cfg_we  = 1'b0;
        begin_frame();
        send_byte(8'hB6, 1'b1, hm);
        check_val("cfg_hits", hm, 8'h90);
        check_val("cfg_cnt", match_cnt, 2);
        step();

        // Saturation: every bit matches, 256 bits must stop at 255
        cfg_we  = 1'b1;
        cfg_pat = 8'h01;
        cfg_len = 3'd0;
        step();
        cfg_we  = 1'b0;
        begin_frame();
        for (int i = 0; i < 32; i++) begin
            send_byte(8'hFF, (i == 31), hm);
            if (i == 30) check_val("sat_cnt_248", match_cnt, 248);
        end
        check_val("sat_hits_last", hm, 8'hFF);
        check_val("sat_cnt_done", match_cnt, 255);
        step();
        check_val("sat_cnt_hold", match_cnt, 255);

        // Reset mid-shift: outputs drop at once, frame is discarded
        begin_frame();
        din      = 8'hB6;
        din_last = 1'b1;
        din_vld  = 1'b1;
        step();
        din_vld  = 1'b0;
        step();
        #1 rst_b = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check_val("async_rst_cnt", match_cnt, 0);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("rst_no_done", done, 0);
            check_val("rst_no_busy", busy, 0);
        end
        begin_frame();
        send_byte(8'hB6, 1'b1, hm);
        check_val("rst_default_hits", hm, 8'h90);
        check_val("rst_default_cnt", match_cnt, 2);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
